rgb_yuv_pipe: RTL and testbench
===============================

// Module: rgb_yuv_pipe
// PURPOSE
//  Parametrised, flow-controlled successor of the fixed 16-bit rgb_yuv converter.
//  It converts one RGB pixel per beat to Y (unsigned) and U/V (signed) using BT.601 or BT.709
//  coefficients, selected per frame.
//  It sits between the pixel source and the chroma/downscale path.
//  Valid/ready handshakes on both sides; frame sideband (sof/eof) stays aligned with its pixel.
// PARAMETERS
//  DW      16  colour component width (R,G,B,Y); U/V are DW+1 bits signed
//  FRAC    14  coefficient fraction bits; all coefficients are unsigned Q0.FRAC
//  LAT      5  pipeline depth in stages; fixed at 5, any other value is a compile-time error
// PORTS
//  clock     in   1       rising-edge clock
//  rst       in   1       synchronous reset, active-high
//  s_valid   in   1       input pixel valid
//  s_ready   out  1       block can accept a pixel this cycle
//  s_sof     in   1       first pixel of a frame (qualified by s_valid)
//  s_eof     in   1       last pixel of a frame (qualified by s_valid)
//  s_mode    in   1       0=BT.601, 1=BT.709; sampled only on an accepted sof beat
//  rdata     in   DW      R component, unsigned
//  gdata     in   DW      G component, unsigned
//  bdata     in   DW      B component, unsigned
//  m_valid   out  1       output pixel valid
//  m_ready   in   1       downstream accepts the output this cycle
//  m_sof     out  1       sof of the output pixel
//  m_eof     out  1       eof of the output pixel
//  m_mode    out  1       coefficient set used for the output pixel
//  ydata     out  DW      Y, unsigned
//  udata     out  DW+1    U, two's complement
//  vdata     out  DW+1    V, two's complement
// BEHAVIOUR
//  - Reset: every stage valid bit = 0, m_valid = 0, all data/sideband outputs = 0, mode_q = 0.
//    A reset mid-frame drops all in-flight pixels; no partial output appears after rst falls.
//  - Advance signal: adv = m_ready | ~m_valid.
//    s_ready = adv (combinational; no combinational path from s_valid).
//  - When adv=0, all stages hold: data, valid and sideband are frozen. Bubbles are not compressed.
//  - Accept: s_valid & s_ready.
//    On an accepted beat with s_sof=1, mode_q <= s_mode and this pixel uses s_mode directly.
//    Otherwise the pixel uses mode_q.
//    s_mode is ignored on all other beats. The mode bit travels with the pixel.
//  - Latency: a pixel accepted in cycle N appears with m_valid=1 in cycle N+5 if no stall occurs.
//    Each stall cycle adds one cycle.
//  - Coefficients (FRAC=14). Scale and round for any other FRAC.
//      BT.601: Kr=4899  Kg=9617  Kb=1868  Ku=8061  Kv=14369
//      BT.709: Kr=3483  Kg=11718 Kb=1183  Ku=8829  Kv=10404
//      In both sets Kr+Kg+Kb = 2^FRAC.
//  - Pipeline stages:
//      S1: pr=Kr*R, pg=Kg*G, pb=Kb*B.
//      S2: ys = pr+pg+pb + 2^(FRAC-1).
//      S3: Y = ys>>FRAC, saturated to 2^DW-1; db = B-Y and dr = R-Y, each signed DW+1.
//      S4: pu = Ku*db, pv = Kv*dr, signed.
//      S5: U = (pu + 2^(FRAC-1)) >>> FRAC; V = (pv + 2^(FRAC-1)) >>> FRAC.
//          The shift is arithmetic, i.e. floor.
//  - Width rules:
//      Intermediate products are full width (DW+FRAC+2 bits); nothing is truncated before S5.
//      |U|,|V| <= 0.877*(2^DW-1) < 2^DW, so U/V never overflow and need no clamp.
//  - Sideband: sof, eof and mode are pipelined in lockstep with valid.
//    sof and eof may both be 1 on the same beat (single-pixel frame).
//  - Outputs hold their value while m_valid & ~m_ready.
//    Once m_valid=1, it stays high until the pixel is accepted.
// TESTING (DW=16, FRAC=14)
//  1. White R=G=B=65535, mode 601, m_ready=1
//     -> 5 cycles later: Y=65535, U=0, V=0.
//  2. Red R=65535, G=B=0, mode 601
//     -> Y=19596, U=-9641, V=40289.
//  3. Red, with sof=1 and s_mode=1 on the accepted beat
//     -> Y=13932, m_mode=1.
//     Next pixel (sof=0, s_mode=0) still reports m_mode=1.
//  4. Stream 20 random pixels; hold m_ready=0 for 7 cycles mid-stream
//     -> s_ready=0 during the stall; no pixel lost or duplicated.
//     Order is preserved and every value matches the model.
//  5. Assert rst for 1 cycle with 3 pixels in flight
//     -> next cycle m_valid=0 and all outputs 0; mode_q=0.
//     No stale pixel emerges later.
//  6. Black pixel 0,0,0 with sof=eof=1
//     -> Y=U=V=0, with m_sof=1 and m_eof=1 on the same output beat.

Source files
------------

// File: rtl/rgb_yuv_pipe.sv
// rgb_yuv_pipe
//   Five-stage, flow-controlled RGB -> YUV converter. One pixel per beat;
//   BT.601 or BT.709 coefficients are chosen on the sof beat of each frame
//   and carried with every pixel of that frame.
//
//   Ports
//     clock, rst              rising-edge clock, synchronous active-high reset
//     s_valid/s_ready         input handshake (s_ready = m_ready | ~m_valid)
//     s_sof/s_eof/s_mode      input frame sideband, mode sampled on sof beats
//     rdata/gdata/bdata       unsigned colour components, DW bits
//     m_valid/m_ready         output handshake
//     m_sof/m_eof/m_mode      output sideband, aligned with the output pixel
//     ydata                   unsigned luma, DW bits
//     udata/vdata             two's complement chroma, DW+1 bits
module rgb_yuv_pipe #(
    parameter int DW   = 16,
    parameter int FRAC = 14,
    parameter int LAT  = 5
) (
    input  logic            clock,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_sof,
    input  logic            s_eof,
    input  logic            s_mode,
    input  logic [DW-1:0]   rdata,
    input  logic [DW-1:0]   gdata,
    input  logic [DW-1:0]   bdata,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_sof,
    output logic            m_eof,
    output logic            m_mode,
    output logic [DW-1:0]   ydata,
    output logic [DW:0]     udata,
    output logic [DW:0]     vdata
);

    if (LAT != 5) begin : g_bad_lat
        $error("rgb_yuv_pipe: LAT must be 5");
    end

    localparam int PW = DW + FRAC + 2;

    // Coefficients are tabulated at 14 fraction bits and rescaled with rounding.
    function automatic logic [FRAC:0] scale_k(input longint k);
        longint r;
        if (FRAC >= 14) r = k <<< (FRAC - 14);
        else            r = (k + (longint'(1) <<< (13 - FRAC))) >>> (14 - FRAC);
        return r[FRAC:0];
    endfunction

    localparam logic [FRAC:0] ONE    = scale_k(longint'(16384));
    localparam logic [FRAC:0] KR_601 = scale_k(4899);
    localparam logic [FRAC:0] KB_601 = scale_k(1868);
    localparam logic [FRAC:0] KG_601 = ONE - KR_601 - KB_601;  // keeps Kr+Kg+Kb exact
    localparam logic [FRAC:0] KU_601 = scale_k(8061);
    localparam logic [FRAC:0] KV_601 = scale_k(14369);
    localparam logic [FRAC:0] KR_709 = scale_k(3483);
    localparam logic [FRAC:0] KB_709 = scale_k(1183);
    localparam logic [FRAC:0] KG_709 = ONE - KR_709 - KB_709;
    localparam logic [FRAC:0] KU_709 = scale_k(8829);
    localparam logic [FRAC:0] KV_709 = scale_k(10404);

    localparam logic [PW-1:0]        HALF   = PW'(1) << (FRAC - 1);
    localparam logic signed [PW-1:0] HALF_S = PW'(1) << (FRAC - 1);
    localparam logic [PW-1:0]        Y_MAX  = PW'((longint'(1) <<< DW) - 1);

    typedef struct packed {
        logic valid;
        logic sof;
        logic eof;
        logic mode;
    } side_t;

    side_t sb [1:5];
    logic  mode_q;
    logic  adv;
    logic  mode_in;

    // Stage data
    logic [PW-1:0]        p_r, p_g, p_b;
    logic [DW-1:0]        r1, b1, r2, b2, y3, y4;
    logic [PW-1:0]        ys2;
    logic signed [DW:0]   db3, dr3;
    logic signed [PW-1:0] pu4, pv4;

    // Combinational helpers
    logic [FRAC:0]        kr, kg, kb, ku, kv;
    logic [PW-1:0]        y_full;
    logic [DW-1:0]        y_sat;

    assign adv     = m_ready | ~sb[5].valid;
    assign s_ready = adv;
    assign mode_in = s_sof ? s_mode : mode_q;

    assign m_valid = sb[5].valid;
    assign m_sof   = sb[5].sof;
    assign m_eof   = sb[5].eof;
    assign m_mode  = sb[5].mode;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through it can leave a value unassigned and infer a latch.
    always_comb begin
        kr = KR_601;
        kg = KG_601;
        kb = KB_601;
        ku = KU_601;
        kv = KV_601;
        if (mode_in) begin
            kr = KR_709;
            kg = KG_709;
            kb = KB_709;
        end
        if (sb[3].mode) begin
            ku = KU_709;
            kv = KV_709;
        end
        y_full = ys2 >> FRAC;
        y_sat  = (y_full > Y_MAX) ? Y_MAX[DW-1:0] : y_full[DW-1:0];
    end

    // Control path: valids, sideband, mode register and output registers.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // stage samples the previous stage's value from before the edge.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 1; i <= 5; i++) sb[i] <= '0;
            mode_q <= 1'b0;
            ydata  <= '0;
            udata  <= '0;
            vdata  <= '0;
        end else if (adv) begin
            sb[1] <= '{valid: s_valid, sof: s_sof & s_valid,
                       eof: s_eof & s_valid, mode: mode_in};
            for (int i = 2; i <= 5; i++) sb[i] <= sb[i-1];
            if (s_valid && s_sof) mode_q <= s_mode;
            ydata <= y4;
            udata <= (DW+1)'((pu4 + HALF_S) >>> FRAC);
            vdata <= (DW+1)'((pv4 + HALF_S) >>> FRAC);
        end
    end

    // Datapath stages 1-4.
    // NOTE: internal data registers are left unreset; their valid bits are
    // cleared, so stale contents can never reach the output.
    always_ff @(posedge clock) begin
        if (adv) begin
            p_r <= PW'(kr) * PW'(rdata);
            p_g <= PW'(kg) * PW'(gdata);
            p_b <= PW'(kb) * PW'(bdata);
            r1  <= rdata;
            b1  <= bdata;

            ys2 <= p_r + p_g + p_b + HALF;
            r2  <= r1;
            b2  <= b1;

            y3  <= y_sat;
            db3 <= $signed({1'b0, b2}) - $signed({1'b0, y_sat});
            dr3 <= $signed({1'b0, r2}) - $signed({1'b0, y_sat});

            pu4 <= PW'(db3) * $signed(PW'(ku));
            pv4 <= PW'(dr3) * $signed(PW'(kv));
            y4  <= y3;
        end
    end

endmodule

// File: tb/tb_rgb_yuv_pipe.sv
// tb_rgb_yuv_pipe
//   Directed bench for rgb_yuv_pipe at DW=16, FRAC=14. Inputs are driven and
//   outputs sampled on the falling clock edge.
module tb_rgb_yuv_pipe;

    logic        clock = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, s_sof, s_eof, s_mode;
    logic [15:0] rdata, gdata, bdata;
    logic        m_valid, m_ready, m_sof, m_eof, m_mode;
    logic [15:0] ydata;
    logic [16:0] udata, vdata;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    rgb_yuv_pipe #(.DW(16), .FRAC(14), .LAT(5)) dut (
        .clock(clock), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_sof(s_sof), .s_eof(s_eof), .s_mode(s_mode),
        .rdata(rdata), .gdata(gdata), .bdata(bdata),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_sof(m_sof), .m_eof(m_eof), .m_mode(m_mode),
        .ydata(ydata), .udata(udata), .vdata(vdata)
    );

    typedef struct {
        logic [15:0] y;
        logic [16:0] u;
        logic [16:0] v;
        logic        sof;
        logic        eof;
        logic        mode;
    } exp_t;

    // Reference arithmetic in 64-bit integers with explicit floor division.
    function automatic longint floor_div(input longint n, input longint d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    task automatic model(input logic [15:0] r, g, b, input logic mode,
                         output logic [15:0] y, output logic [16:0] u, v);
        longint kr, kg, kb, ku, kv, yy, uu, vv;
        if (mode) begin kr = 3483; kg = 11718; kb = 1183; ku = 8829; kv = 10404; end
        else      begin kr = 4899; kg = 9617;  kb = 1868; ku = 8061; kv = 14369; end
        yy = (kr * r + kg * g + kb * b + 8192) / 16384;
        if (yy > 65535) yy = 65535;
        uu = floor_div(ku * (longint'(b) - yy) + 8192, 16384);
        vv = floor_div(kv * (longint'(r) - yy) + 8192, 16384);
        y = yy[15:0];
        u = uu[16:0];
        v = vv[16:0];
    endtask

    // One-beat pixel, assuming the pipe is ready; returns on the next falling edge.
    task automatic drive_pixel(input logic [15:0] r, g, b, input logic sof, eof, mode);
        @(negedge clock);
        s_valid = 1'b1; rdata = r; gdata = g; bdata = b;
        s_sof = sof; s_eof = eof; s_mode = mode;
        @(negedge clock);
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0; s_mode = 1'b0;
    endtask

    // lat counts cycles since the accepting cycle; stops at 20.
    task automatic wait_out(output int lat);
        lat = 1;
        while (m_valid !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; m_ready = 1'b1;
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0; s_mode = 1'b0;
        rdata = '0; gdata = '0; bdata = '0;
        repeat (2) @(negedge clock);
        rst = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || ydata !== 16'd0 || udata !== 17'd0 || vdata !== 17'd0 ||
            m_sof !== 1'b0 || m_eof !== 1'b0 || m_mode !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b y=%0d u=%0d v=%0d sof=%b eof=%b mode=%b, want all 0",
                     m_valid, ydata, udata, vdata, m_sof, m_eof, m_mode);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_s_ready: got %b want 1", s_ready);
        end
    endtask

    task automatic test_white();
        int lat;
        drive_pixel(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        wait_out(lat);
        checks++;
        if (m_valid !== 1'b1 || lat !== 5) begin
            errors++;
            $display("FAIL white_latency: got valid=%b lat=%0d want valid=1 lat=5", m_valid, lat);
        end
        checks++;
        if (ydata !== 16'd65535 || udata !== 17'd0 || vdata !== 17'd0 || m_mode !== 1'b0) begin
            errors++;
            $display("FAIL white_yuv: got y=%0d u=%0d v=%0d mode=%b want 65535 0 0 0",
                     ydata, $signed(udata), $signed(vdata), m_mode);
        end
    endtask

    task automatic test_red_hold();
        int lat;
        drive_pixel(16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        m_ready = 1'b0;
        wait_out(lat);
        checks++;
        if (m_valid !== 1'b1 || ydata !== 16'd19596 || udata !== 17'(-9641) ||
            vdata !== 17'd40289) begin
            errors++;
            $display("FAIL red601_yuv: got valid=%b y=%0d u=%0d v=%0d want 1 19596 -9641 40289",
                     m_valid, ydata, $signed(udata), $signed(vdata));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || ydata !== 16'd19596 ||
                vdata !== 17'd40289) begin
                errors++;
                $display("FAIL hold_stall%0d: got valid=%b s_ready=%b y=%0d v=%0d want 1 0 19596 40289",
                         i, m_valid, s_ready, ydata, $signed(vdata));
            end
        end
        m_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_mode_709();
        int lat;
        drive_pixel(16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
        wait_out(lat);
        checks++;
        if (m_valid !== 1'b1 || ydata !== 16'd13932 || udata !== 17'(-7508) ||
            vdata !== 17'd32768 || m_mode !== 1'b1 || m_sof !== 1'b1) begin
            errors++;
            $display("FAIL red709_yuv: got valid=%b y=%0d u=%0d v=%0d mode=%b sof=%b want 1 13932 -7508 32768 1 1",
                     m_valid, ydata, $signed(udata), $signed(vdata), m_mode, m_sof);
        end
        drive_pixel(16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        wait_out(lat);
        checks++;
        if (m_valid !== 1'b1 || ydata !== 16'd13932 || m_mode !== 1'b1 || m_sof !== 1'b0) begin
            errors++;
            $display("FAIL mode_sticky: got valid=%b y=%0d mode=%b sof=%b want 1 13932 1 0",
                     m_valid, ydata, m_mode, m_sof);
        end
    endtask

    task automatic test_stream();
        logic [15:0] sr [20], sg [20], sbv [20];
        logic        ssof [20], seof [20], smode [20];
        exp_t        q [$];
        exp_t        e;
        logic        mq = 1'b1;
        int          sent = 0, recv = 0, stall_seen = 0;
        for (int i = 0; i < 20; i++) begin
            sr[i] = 16'($urandom); sg[i] = 16'($urandom); sbv[i] = 16'($urandom);
            ssof[i] = (i == 0 || i == 10);
            seof[i] = (i == 9 || i == 19);
            smode[i] = (i == 0) ? 1'b1 : (i == 10) ? 1'b0 : 1'($urandom);
        end
        for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
            @(negedge clock);
            m_ready = !(cyc >= 8 && cyc < 15);
            if (sent < 20) begin
                s_valid = 1'b1; rdata = sr[sent]; gdata = sg[sent]; bdata = sbv[sent];
                s_sof = ssof[sent]; s_eof = seof[sent]; s_mode = smode[sent];
            end else begin
                s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
            end
            #1;
            if (!m_ready && m_valid) begin
                stall_seen++;
                checks++;
                if (s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_stall_ready cyc%0d: got s_ready=%b want 0", cyc, s_ready);
                end
            end
            if (m_valid === 1'b1 && m_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: got unexpected pixel y=%0d want none", ydata);
                end else begin
                    e = q.pop_front();
                    if (ydata !== e.y || udata !== e.u || vdata !== e.v ||
                        m_sof !== e.sof || m_eof !== e.eof || m_mode !== e.mode) begin
                        errors++;
                        $display("FAIL stream_pix%0d: got y=%0d u=%0d v=%0d sof=%b eof=%b mode=%b want %0d %0d %0d %b %b %b",
                                 recv, ydata, $signed(udata), $signed(vdata), m_sof, m_eof, m_mode,
                                 e.y, $signed(e.u), $signed(e.v), e.sof, e.eof, e.mode);
                    end
                end
                recv++;
            end
            if (s_valid && s_ready === 1'b1) begin
                if (ssof[sent]) mq = smode[sent];
                e.mode = mq;
                e.sof = ssof[sent];
                e.eof = seof[sent];
                model(sr[sent], sg[sent], sbv[sent], mq, e.y, e.u, e.v);
                q.push_back(e);
                sent++;
            end
        end
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0; m_ready = 1'b1;
        checks++;
        if (sent !== 20 || recv !== 20 || q.size() !== 0 || stall_seen !== 7) begin
            errors++;
            $display("FAIL stream_count: got sent=%0d recv=%0d left=%0d stalls=%0d want 20 20 0 7",
                     sent, recv, q.size(), stall_seen);
        end
    endtask

    task automatic test_reset_midframe();
        int lat;
        int stale = 0;
        @(negedge clock);
        s_valid = 1'b1; rdata = 16'd1000; gdata = 16'd2000; bdata = 16'd3000;
        s_sof = 1'b1; s_mode = 1'b1;
        @(negedge clock);
        s_sof = 1'b0; s_mode = 1'b0;
        repeat (2) @(negedge clock);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || ydata !== 16'd0 || udata !== 17'd0 || vdata !== 17'd0 ||
            m_sof !== 1'b0 || m_eof !== 1'b0 || m_mode !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got valid=%b y=%0d u=%0d v=%0d sof=%b eof=%b mode=%b want all 0",
                     m_valid, ydata, udata, vdata, m_sof, m_eof, m_mode);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (m_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL midreset_stale: got %0d valid beats want 0", stale);
        end
        // mode_q must be back at 601: a non-sof beat with s_mode=1 is ignored.
        drive_pixel(16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        wait_out(lat);
        checks++;
        if (m_valid !== 1'b1 || lat !== 5 || m_mode !== 1'b0 || ydata !== 16'd19596) begin
            errors++;
            $display("FAIL midreset_mode: got valid=%b lat=%0d mode=%b y=%0d want 1 5 0 19596",
                     m_valid, lat, m_mode, ydata);
        end
    endtask

    task automatic test_black_single();
        int lat;
        drive_pixel(16'd0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);
        wait_out(lat);
        checks++;
        if (m_valid !== 1'b1 || ydata !== 16'd0 || udata !== 17'd0 || vdata !== 17'd0 ||
            m_sof !== 1'b1 || m_eof !== 1'b1 || m_mode !== 1'b0) begin
            errors++;
            $display("FAIL black_sof_eof: got valid=%b y=%0d u=%0d v=%0d sof=%b eof=%b mode=%b want 1 0 0 0 1 1 0",
                     m_valid, ydata, $signed(udata), $signed(vdata), m_sof, m_eof, m_mode);
        end
        @(negedge clock);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL black_single_beat: got valid=%b want 0", m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_white();
        test_red_hold();
        test_mode_709();
        test_stream();
        test_reset_midframe();
        test_black_single();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
